// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM
// states and the byte-enable patterns driven onto the BRAM data port.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables and lane replication, plus load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_lane
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    be        = BE_NONE;
    wdata_rep = wdata;
    rdata_ext = rdata;
    ld_byte   = rdata[8*lane +: 8];
    ld_half   = rdata[16*lane[1] +: 16];
    case (size)
      SZ_BYTE: begin
        be        = BE_BYTE0 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = zero_ext ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        be        = lane[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = zero_ext ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      SZ_WORD: begin
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: begin
        be        = BE_NONE;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for port B of the main-memory BRAM. One request at a
// time: IDLE -> ISSUE -> (WAIT) -> RESP, faults go straight to RESP.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int MEM_SIZE = 8192
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         resp_valid,
  output logic [31:0]                  resp_rdata,
  output logic                         resp_fault,
  output logic [$clog2(MEM_SIZE)-1:0]  mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata,
  output logic [3:0]                   mem_be,
  output logic                         mem_we
);

  localparam int AW = $clog2(MEM_SIZE);

  state_e      state;
  logic        write_q;
  size_e       size_q;
  logic        zext_q;
  logic [31:0] wdata_q;
  logic        fault;
  logic        issuing;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign fault = (req_size == 2'b11)
              || (req_size == SZ_HALF && req_addr[0])
              || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
              || (req_addr >= 32'(MEM_SIZE));

  // mem_addr doubles as the registered request address, so lane select comes
  // from its low bits and it naturally holds between accesses.
  lsu_lane u_lane (
    .size      (size_q),
    .lane      (mem_addr[1:0]),
    .zero_ext  (zext_q),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // Strobes are gated by rst so a store caught by reset mid-ISSUE never writes.
  assign req_ready = (state == IDLE) && !rst;
  assign issuing   = (state == ISSUE) && !rst;
  assign mem_we    = issuing && write_q;
  assign mem_be    = issuing ? lane_be : BE_NONE;
  assign mem_wdata = lane_wdata;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      write_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      zext_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state    <= ISSUE;
              mem_addr <= req_addr[AW-1:0];
              write_q  <= req_write;
              size_q   <= size_e'(req_size);
              zext_q   <= req_unsigned;
              wdata_q  <= req_wdata;
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= lane_rdata;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a byte-array reference model predicts each
// response and write; monitors compare whatever the DUT presents.
module tb_mem_lsu;

  localparam int MEM_SIZE = 8192;
  localparam int WORDS    = MEM_SIZE / 4;
  localparam int AW       = $clog2(MEM_SIZE);

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [3:0]    mem_be;
  logic          mem_we;

  mem_lsu #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_be       (mem_be),
    .mem_we       (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port B: synchronous read, one cycle latency, byte-enabled write.
  logic [31:0] bram [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) bram[mem_addr[AW-1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= bram[mem_addr[AW-1:2]];
  end

  logic [7:0] ref_mem [0:MEM_SIZE-1];

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [AW-3:0] widx;
    logic [3:0]    be;
    logic [31:0]   wdata;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  resp_t mon_r;
  wr_t   mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_r = resp_q.pop_front();
        check("resp_rdata", resp_rdata, mon_r.rdata);
        check("resp_fault", {31'b0, resp_fault}, {31'b0, mon_r.fault});
        check("resp_latency", 32'(cyc - mon_r.acc), 32'(mon_r.lat));
      end
    end
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("write_unexpected", 32'd1, 32'd0);
      end else begin
        mon_w = wr_q.pop_front();
        check("write_addr", 32'(mem_addr[AW-1:2]), 32'(mon_w.widx));
        check("write_be", {28'b0, mem_be}, {28'b0, mon_w.be});
        check("write_data", mem_wdata, mon_w.wdata);
      end
    end
  end

  // Drives one request, waits for acceptance and, when tracked, predicts the
  // outcome from the byte-level reference memory.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit track,
                       output int acc, output int waited);
    resp_t e;
    wr_t   x;
    int    n;
    logic [31:0] v;
    bit    flt;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    waited       = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (track) begin
      flt = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
         || (a >= 32'(MEM_SIZE));
      e.fault = flt;
      e.acc   = acc;
      e.rdata = '0;
      e.lat   = flt ? 0 : (w ? 1 : 2);
      if (!flt) begin
        n = 1 << sz;
        if (w) begin
          x.widx  = a[AW-1:2];
          x.be    = 4'((1 << n) - 1) << a[1:0];
          x.wdata = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
          wr_q.push_back(x);
          for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
        end else begin
          v = '0;
          for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
          if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
          e.rdata = v;
        end
      end
      resp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc1, acc2, w1, w2, budget;
    logic [31:0] word;
    logic [31:0] ra;

    for (int wi = 0; wi < WORDS; wi++) begin
      word = 32'(wi) * 32'h9E3779B1;
      if (wi == 4) word = 32'h8899AABB;
      if (wi == 8) word = 32'h13572468;
      bram[wi] = word;
      for (int b = 0; b < 4; b++) ref_mem[4*wi + b] = word[8*b +: 8];
    end

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_resp_fault", {31'b0, resp_fault}, 32'd0);
    check("reset_mem_we", {31'b0, mem_we}, 32'd0);
    check("reset_mem_be", {28'b0, mem_be}, 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Loads of the preloaded word in all sizes and extensions.
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, acc1, w1);
    issue(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b1, acc1, w1);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, acc1, w1);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, acc1, w1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, acc1, w1);

    // Byte store then word readback.
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000005A, 1'b1, acc1, w1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, acc1, w1);

    // Faulting requests.
    issue(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 1'b1, acc1, w1);
    issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 1'b1, acc1, w1);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, acc1, w1);
    issue(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 1'b1, acc1, w1);

    // Back-to-back loads with req_valid held high.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, acc1, w1);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, acc2, w2);
    check("b2b_ready_low_cycles", 32'(w2), 32'd3);
    check("b2b_accept_spacing", 32'(acc2 - acc1), 32'd4);

    // Store aborted by reset during ISSUE: no write, no response.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0, acc1, w1);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", {31'b0, req_ready}, 32'd1);
    check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, acc1, w1);

    // Randomized mix, including misaligned, illegal and out-of-range requests.
    for (int k = 0; k < 200; k++) begin
      ra = ($urandom_range(0, 15) == 0) ? 32'h2000 + $urandom_range(0, 255)
                                        : 32'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ra, $urandom, 1'b1, acc1, w1);
    end

    budget = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("drain_resp_queue", 32'(resp_q.size()), 32'd0);
    check("drain_write_queue", 32'(wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator that drives the data port (port B) of the dual-port BRAM main memory on behalf of the CPU pipeline.
- Accepts one byte, half or word request at a time over a valid/ready handshake.
- Loads: computes the aligned word address, waits the BRAM's 1-cycle read latency, then extracts and sign/zero-extends the addressed lane.
- Stores: generates the byte enables and replicates write data across lanes.
- Misaligned, out-of-range or illegal-size requests fault without touching memory.

Parameters:
MEM_SIZE, 8192, bytes of main memory; must match the memory instance. mem_addr width is $clog2(MEM_SIZE).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend loads (ignored for word and stores)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  request faulted (qualified by resp_valid)
mem_addr  out  $clog2(MEM_SIZE)  byte address to memory (low 2 bits ignored by memory)
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory port-B read data (valid 1 cycle after address)
mem_be  out  4  byte enables, bit i = byte lane i
mem_we  out  1  write strobe

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- Reset: state IDLE. resp_valid, resp_fault, mem_we and mem_be are 0; resp_rdata and mem_addr are 0. req_ready is 0 while rst is high.
- FSM states IDLE, ISSUE, WAIT, RESP. req_ready = (state==IDLE) && !rst.
- Accept: on req_valid && req_ready at the end of cycle N, register the request fields.
- Fault check at accept: fault if any of:
  - req_size==11;
  - half with addr[0]!=0;
  - word with addr[1:0]!=0;
  - req_addr >= MEM_SIZE.
  A faulting request goes IDLE->RESP; resp_valid=1 and resp_fault=1 in cycle N+1; memory is never accessed.
- ISSUE (cycle N+1):
  - mem_addr = registered addr.
  - Store: mem_we=1.
  - mem_be: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - mem_wdata: byte replicated 4x, half replicated 2x, word as-is.
  - Loads go to WAIT, stores go to RESP.
- WAIT (loads, cycle N+2): mem_rdata is valid. Extract:
  - byte lane addr[1:0] at bits [8*lane +: 8];
  - half at [16*addr[1] +: 16];
  - sign-extend unless req_unsigned;
  - register the result into resp_rdata; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latencies from the accept edge: load response at N+3, store response at N+2, fault response at N+1.
- Outside ISSUE: mem_we=0 and mem_be=0000. mem_addr holds its last value.
- Back-to-back requests: the next request can be accepted in the first IDLE cycle after RESP. There is no pipelining.
- Reset mid-operation: the operation is aborted and no resp_valid is produced. mem_we is gated by !rst, so a store whose ISSUE cycle coincides with rst writes nothing.
- resp_rdata holds its value until the next response.

Decomposition:
- mem_pkg holds:
  - access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - FSM state enum;
  - byte-enable constants.
- One combinational sub-module, lsu_lane: generates mem_be and mem_wdata from size/addr/wdata, and does load lane extraction and extension from size/addr/unsigned/rdata.
- The FSM, registers and fault check stay in mem_lsu.

Test Plan:
Preload word 0x10 = 0x8899AABB; pair with the memory model (1-cycle read latency, byte enables).
1. Load byte signed at 0x13 -> resp_rdata=0xFFFFFF88, resp_fault=0, resp_valid exactly 3 cycles after accept; load byte unsigned at 0x10 -> 0x000000BB.
2. Load half unsigned at 0x12 -> 0x00008899; load half signed at 0x12 -> 0xFFFF8899; load word at 0x10 -> 0x8899AABB.
3. Store byte 0x5A at 0x11 -> single cycle with mem_we=1, mem_be=0010, mem_wdata=0x5A5A5A5A, resp_valid 2 cycles after accept; then load word at 0x10 -> 0x88995ABB.
4. Each of the following -> resp_fault=1 at N+1, resp_rdata=0, mem_we never asserted:
   - load word at 0x0E;
   - store half at 0x11;
   - size 11;
   - load word at 0x2000 with MEM_SIZE=8192.
5. Two loads with req_valid held high -> req_ready=0 through ISSUE/WAIT/RESP; second request accepted the cycle after the first resp_valid; both results correct.
6. Store word 0xDEADBEEF at 0x20 with rst asserted during its ISSUE cycle -> no resp_valid, FSM in IDLE, mem_we=0 throughout; a later load from 0x20 returns the preloaded value.
